// File: rtl/instr_cache_pkg.sv
// Shared core package: ISA opcodes plus instruction-cache geometry and FSM state.
package instr_cache_pkg;

    // ISA opcode field (top nibble of each 16-bit instruction)
    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LOAD = 4'h1,
        OP_STOR = 4'h2,
        OP_ADD  = 4'h3,
        OP_SUB  = 4'h4,
        OP_JMP  = 4'h8,
        OP_CALL = 4'h9,
        OP_RET  = 4'hA
    } opcode_e;

    // Instruction cache geometry (defaults; the cache module may override)
    localparam int IC_LINES  = 16;
    localparam int IC_WORDS  = 4;
    localparam int IC_AW     = 12;   // program byte address width
    localparam int IC_DW     = 16;   // instruction width
    localparam int IC_WORD_W = $clog2(IC_WORDS);
    localparam int IC_IDX_W  = $clog2(IC_LINES);
    localparam int IC_TAG_W  = IC_AW - 1 - IC_WORD_W - IC_IDX_W;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } ic_state_e;

endpackage

// File: rtl/instr_cache_data_ram.sv
// Instruction cache data array: one write port, one asynchronous read port.
module icache_data_ram #(
    parameter int LINES  = 16,
    parameter int WORDS  = 4,
    parameter int IDX_W  = 4,
    parameter int WORD_W = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [WORD_W-1:0] wword,
    input  logic [15:0]       wdata,
    input  logic [IDX_W-1:0]  ridx,
    input  logic [WORD_W-1:0] rword,
    output logic [15:0]       rdata
);

    logic [15:0] mem_q [LINES][WORDS];

    // Fill data written one word per memory ack; contents are never reset
    always_ff @(posedge clk) begin
        if (we) mem_q[widx][wword] <= wdata;
    end

    assign rdata = mem_q[ridx][rword];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped instruction cache with whole-line fill from program memory.
module instr_cache
    import instr_cache_pkg::*;
#(
    parameter int LINES = IC_LINES,
    parameter int WORDS = IC_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] fetch_addr,
    input  logic        fetch_en,
    input  logic        flush,
    output logic [15:0] instruction,
    output logic        instr_valid,
    output logic        stall,
    output logic        mem_req,
    output logic [11:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
);

    localparam int WW = $clog2(WORDS);
    localparam int IW = $clog2(LINES);
    localparam int TW = IC_AW - 1 - WW - IW;

    ic_state_e         state_q, state_d;
    logic [11:0]       cur_addr_q;
    logic [WW-1:0]     fill_cnt_q, fill_cnt_d;
    logic              flush_pend_q, flush_pend_d;
    logic [LINES-1:0]  valid_q;
    logic [TW-1:0]     tag_q [LINES];

    logic [WW-1:0]     cur_word;
    logic [IW-1:0]     cur_idx;
    logic [TW-1:0]     cur_tag;
    logic              hit, rst_pending;
    logic              ram_we, line_fill, clr_valid;
    logic [15:0]       rd_data;
    logic              unused_bit0;

    assign cur_word    = cur_addr_q[WW:1];
    assign cur_idx     = cur_addr_q[WW+IW:WW+1];
    assign cur_tag     = cur_addr_q[11:WW+IW+1];
    assign unused_bit0 = cur_addr_q[0];

    // Arrays may still hold pre-reset contents while rst is high
    assign rst_pending = rst;
    assign hit         = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);
    assign instr_valid = hit && (state_q == S_IDLE) && !rst_pending;
    assign stall       = !instr_valid;
    assign instruction = instr_valid ? rd_data : 16'h0000;

    // Next-state, fill bookkeeping and memory request generation
    always_comb begin
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        flush_pend_d = flush_pend_q;
        ram_we       = 1'b0;
        line_fill    = 1'b0;
        clr_valid    = 1'b0;
        mem_req      = 1'b0;
        mem_addr     = 12'h000;
        case (state_q)
            S_IDLE: begin
                if (flush) clr_valid = 1'b1;
                if (!hit) begin
                    state_d    = S_FILL;
                    fill_cnt_d = '0;
                end
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {cur_tag, cur_idx, fill_cnt_q, 1'b0};
                if (flush) flush_pend_d = 1'b1;
                if (mem_ack) begin
                    ram_we     = 1'b1;
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    if (fill_cnt_q == WW'(WORDS - 1)) begin
                        state_d      = S_IDLE;
                        fill_cnt_d   = '0;
                        flush_pend_d = 1'b0;
                        // A flush seen during the fill wins: line stays invalid
                        if (flush_pend_q || flush) clr_valid = 1'b1;
                        else                       line_fill = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, fetch address and valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            fill_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            cur_addr_q   <= 12'h000;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            flush_pend_q <= flush_pend_d;
            if (fetch_en && !stall) cur_addr_q <= fetch_addr;
            if (clr_valid)      valid_q          <= '0;
            else if (line_fill) valid_q[cur_idx] <= 1'b1;
        end
    end

    // Tag written when a line completes cleanly; not reset
    always_ff @(posedge clk) begin
        if (line_fill) tag_q[cur_idx] <= cur_tag;
    end

    icache_data_ram #(
        .LINES (LINES),
        .WORDS (WORDS),
        .IDX_W (IW),
        .WORD_W(WW)
    ) u_data (
        .clk  (clk),
        .we   (ram_we),
        .widx (cur_idx),
        .wword(fill_cnt_q),
        .wdata(mem_rdata),
        .ridx (cur_idx),
        .rword(cur_word),
        .rdata(rd_data)
    );

endmodule
